// File: rtl/mc_pkg.sv
// Shared types and opcode constants for the multicycle controller.
// Imported by mc_immdec and multicycle_ctrl.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/mc_immdec.sv
// Immediate-format select: purely combinational function of the opcode.
module mc_immdec
  import mc_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_STORE:  imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      OP_JAL:    imm_src = 2'b11;
      default:   imm_src = 2'b00;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM controller for a multicycle RISC-V datapath with retired-instruction counter.
// Optional MC_MEMWAIT_EN: FETCH, MEMREAD and MEMWRITE stall until mem_ready=1.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  op,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  ImmSrc,
  output logic        illegal_op,
  output logic [31:0] instret,
  output logic [3:0]  state_o
);

  state_t      state, state_nxt;
  logic [31:0] instret_q;
  logic        pc_update, branch, retire;
  logic        adr_src, mem_write, ir_write, reg_write, illegal;

`ifndef MC_MEMWAIT_EN
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      instret_q <= '0;
    end else begin
      state <= state_nxt;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_update = 1'b0;
    branch    = 1'b0;
    retire    = 1'b0;
    adr_src   = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (state)
      FETCH: begin
        ResultSrc = 2'b10;
        ALUSrcB   = 2'b10;
        ir_write  = 1'b1;
        pc_update = 1'b1;
        state_nxt = DECODE;
`ifdef MC_MEMWAIT_EN
        if (!mem_ready) begin
          ir_write  = 1'b0;
          pc_update = 1'b0;
          state_nxt = FETCH;
        end
`endif
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_nxt = MEMADR;
          OP_RTYPE:          state_nxt = EXECR;
          OP_ITYPE:          state_nxt = EXECI;
          OP_BRANCH:         state_nxt = BEQ;
          OP_JAL:            state_nxt = JAL;
          default: begin
            illegal   = 1'b1;
            state_nxt = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        state_nxt = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src   = 1'b1;
        state_nxt = MEMWB;
`ifdef MC_MEMWAIT_EN
        if (!mem_ready) state_nxt = MEMREAD;
`endif
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = 1'b1;
        state_nxt = FETCH;
`ifdef MC_MEMWAIT_EN
        // MemWrite stays up across the stall; the store commits on the ready cycle.
        if (!mem_ready) begin
          retire    = 1'b0;
          state_nxt = MEMWRITE;
        end
`endif
      end
      EXECR: begin
        ALUSrcA   = 2'b10;
        ALUOp     = 2'b10;
        state_nxt = ALUWB;
      end
      EXECI: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ALUOp     = 2'b10;
        state_nxt = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      BEQ: begin
        ALUSrcA   = 2'b10;
        ALUOp     = 2'b01;
        branch    = 1'b1;
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_nxt = ALUWB;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Strobes are gated by rst_n so an asynchronous reset silences them in the same cycle.
  assign PCWrite    = rst_n & (pc_update | (branch & Zero));
  assign IRWrite    = rst_n & ir_write;
  assign RegWrite   = rst_n & reg_write;
  assign MemWrite   = rst_n & mem_write;
  assign illegal_op = rst_n & illegal;
  assign AdrSrc     = adr_src;
  assign instret    = instret_q;
  assign state_o    = state;

  mc_immdec u_immdec (
    .op      (op),
    .imm_src (ImmSrc)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_ctrl;
  import mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  op = 7'b0000011;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic        illegal_op;
  logic [31:0] instret;
  logic [3:0]  state_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [12:0] ctl;
    logic [1:0]  imm;
    logic        ill;
    logic [31:0] ir;
  } exp_t;

  exp_t exp_q[$];

  // ctl = {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
  localparam logic [12:0] C_RST  = 13'b0_0_0_0_0_10_00_10_00;
  localparam logic [12:0] C_F    = 13'b1_0_0_1_0_10_00_10_00;
  localparam logic [12:0] C_D    = 13'b0_0_0_0_0_00_01_01_00;
  localparam logic [12:0] C_MA   = 13'b0_0_0_0_0_00_10_01_00;
  localparam logic [12:0] C_MR   = 13'b0_1_0_0_0_00_00_00_00;
  localparam logic [12:0] C_MWB  = 13'b0_0_0_0_1_01_00_00_00;
  localparam logic [12:0] C_MW   = 13'b0_1_1_0_0_00_00_00_00;
  localparam logic [12:0] C_ER   = 13'b0_0_0_0_0_00_10_00_10;
  localparam logic [12:0] C_EI   = 13'b0_0_0_0_0_00_10_01_10;
  localparam logic [12:0] C_AW   = 13'b0_0_0_0_1_00_00_00_00;
  localparam logic [12:0] C_BEQ1 = 13'b1_0_0_0_0_00_10_00_01;
  localparam logic [12:0] C_BEQ0 = 13'b0_0_0_0_0_00_10_00_01;
  localparam logic [12:0] C_J    = 13'b1_0_0_0_0_00_01_10_00;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .ImmSrc     (ImmSrc),
    .illegal_op (illegal_op),
    .instret    (instret),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  // One clock of stimulus: drive inputs just after the edge, queue the expected outputs.
  task automatic step(input logic rst, input logic [6:0] op_i, input logic z, input logic mr,
                      input state_t st, input logic [12:0] ctl, input logic [1:0] imm,
                      input logic ill, input logic [31:0] ir);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n     = rst;
    op        = op_i;
    Zero      = z;
    mem_ready = mr;
    e.st  = st;
    e.ctl = ctl;
    e.imm = imm;
    e.ill = ill;
    e.ir  = ir;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("state", 32'(state_o), 32'(e.st));
      chk("ctl", 32'({PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                      ResultSrc, ALUSrcA, ALUSrcB, ALUOp}), 32'(e.ctl));
      chk("immsrc", 32'(ImmSrc), 32'(e.imm));
      chk("illegal_op", 32'(illegal_op), 32'(e.ill));
      chk("instret", instret, e.ir);
    end
  end

  initial begin
    // reset held, then lw
    step(0, LW, 0, 1, FETCH,   C_RST, 2'b00, 0, 0);
    step(0, LW, 0, 1, FETCH,   C_RST, 2'b00, 0, 0);
    step(1, LW, 0, 1, FETCH,   C_F,   2'b00, 0, 0);
    step(1, LW, 0, 1, DECODE,  C_D,   2'b00, 0, 0);
    step(1, LW, 0, 1, MEMADR,  C_MA,  2'b00, 0, 0);
    step(1, LW, 0, 1, MEMREAD, C_MR,  2'b00, 0, 0);
    step(1, LW, 0, 1, MEMWB,   C_MWB, 2'b00, 0, 0);
    // sw
    step(1, SW, 0, 1, FETCH,    C_F,  2'b01, 0, 1);
    step(1, SW, 0, 1, DECODE,   C_D,  2'b01, 0, 1);
    step(1, SW, 0, 1, MEMADR,   C_MA, 2'b01, 0, 1);
    step(1, SW, 0, 1, MEMWRITE, C_MW, 2'b01, 0, 1);
    // R-type
    step(1, RT, 0, 1, FETCH,  C_F,  2'b00, 0, 2);
    step(1, RT, 0, 1, DECODE, C_D,  2'b00, 0, 2);
    step(1, RT, 0, 1, EXECR,  C_ER, 2'b00, 0, 2);
    step(1, RT, 0, 1, ALUWB,  C_AW, 2'b00, 0, 2);
    // I-type
    step(1, IT, 0, 1, FETCH,  C_F,  2'b00, 0, 3);
    step(1, IT, 0, 1, DECODE, C_D,  2'b00, 0, 3);
    step(1, IT, 0, 1, EXECI,  C_EI, 2'b00, 0, 3);
    step(1, IT, 0, 1, ALUWB,  C_AW, 2'b00, 0, 3);
    // beq taken, then not taken
    step(1, BR, 0, 1, FETCH,  C_F,    2'b10, 0, 4);
    step(1, BR, 0, 1, DECODE, C_D,    2'b10, 0, 4);
    step(1, BR, 1, 1, BEQ,    C_BEQ1, 2'b10, 0, 4);
    step(1, BR, 0, 1, FETCH,  C_F,    2'b10, 0, 5);
    step(1, BR, 0, 1, DECODE, C_D,    2'b10, 0, 5);
    step(1, BR, 0, 1, BEQ,    C_BEQ0, 2'b10, 0, 5);
    // jal
    step(1, JL, 0, 1, FETCH,  C_F,  2'b11, 0, 6);
    step(1, JL, 0, 1, DECODE, C_D,  2'b11, 0, 6);
    step(1, JL, 0, 1, JAL,    C_J,  2'b11, 0, 6);
    step(1, JL, 0, 1, ALUWB,  C_AW, 2'b11, 0, 6);
    // illegal opcode
    step(1, BAD, 0, 1, FETCH,  C_F, 2'b00, 0, 7);
    step(1, BAD, 0, 1, DECODE, C_D, 2'b00, 1, 7);
    step(1, RT,  0, 1, FETCH,  C_F, 2'b00, 0, 7);
    // R-type aborted by reset in EXECR
    step(1, RT, 0, 1, DECODE, C_D,  2'b00, 0, 7);
    step(1, RT, 0, 1, EXECR,  C_ER, 2'b00, 0, 7);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(state_o), 32'(FETCH));
    chk("async_rst_strobes", 32'({PCWrite, MemWrite, IRWrite, RegWrite, illegal_op}), 32'd0);
    step(0, RT, 0, 1, FETCH, C_RST, 2'b00, 0, 0);
    step(1, RT, 0, 1, FETCH, C_F,   2'b00, 0, 0);
    // counter wrap
    @(negedge clk);
    #1;
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    step(1, RT, 0, 1, DECODE, C_D,  2'b00, 0, 32'hFFFF_FFFF);
    step(1, RT, 0, 1, EXECR,  C_ER, 2'b00, 0, 32'hFFFF_FFFF);
    step(1, RT, 0, 1, ALUWB,  C_AW, 2'b00, 0, 32'hFFFF_FFFF);
    step(1, SW, 0, 1, FETCH,  C_F,  2'b01, 0, 0);
`ifdef MC_MEMWAIT_EN
    // sw with three wait cycles in MEMWRITE, then a stalled FETCH
    step(1, SW, 0, 1, DECODE,   C_D,   2'b01, 0, 0);
    step(1, SW, 0, 1, MEMADR,   C_MA,  2'b01, 0, 0);
    step(1, SW, 0, 0, MEMWRITE, C_MW,  2'b01, 0, 0);
    step(1, SW, 0, 0, MEMWRITE, C_MW,  2'b01, 0, 0);
    step(1, SW, 0, 0, MEMWRITE, C_MW,  2'b01, 0, 0);
    step(1, SW, 0, 1, MEMWRITE, C_MW,  2'b01, 0, 0);
    step(1, SW, 0, 0, FETCH,    C_RST, 2'b01, 0, 1);
    step(1, SW, 0, 0, FETCH,    C_RST, 2'b01, 0, 1);
    step(1, SW, 0, 1, FETCH,    C_F,   2'b01, 0, 1);
    step(1, SW, 0, 1, DECODE,   C_D,   2'b01, 0, 1);
`endif
    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
